btb_assoc: RTL
==============

Name: btb_assoc

Overview:
- Parametrised N-way set-associative branch target buffer that owns its own storage, replacement state and 2-bit predictors.
- Successor to the 2-way/8-set fixed-format BTB lookup; adds configurable sets/ways, registered lookup, allocation/update from EX, true-LRU replacement and flush.
- Sits between IF (lookup by fetch PC) and EX (resolved-branch update).

Parameters:
- NUM_SETS, 8, number of sets; power of two, at least 2; IDX_W = log2(NUM_SETS).
- NUM_WAYS, 2, ways per set; power of two, at least 2; AGE_W = log2(NUM_WAYS).
- PC_W, 32, PC and target width; TAG_W = PC_W - 2 - IDX_W (PC[1:0] ignored).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  invalidate all entries this cycle.
- rd_req  in  1  lookup request (IF).
- rd_pc  in  PC_W  fetch PC.
- rd_vld  out  1  registered: lookup result valid.
- rd_hit  out  1  registered: tag hit.
- rd_taken  out  1  registered: predicted taken (counter MSB).
- rd_target  out  PC_W  registered: predicted target; 0 on miss.
- upd_en  in  1  resolved branch update (EX).
- upd_pc  in  PC_W  branch PC.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_W  actual target.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].
- Entry fields: valid, tag, target, state[1:0], age[AGE_W-1:0].
- Counter encoding:
  - SNT = 00, WNT = 01, ST = 10, WT = 11; predicted taken = state[1].
  - On taken: 00→01→11→10, saturate at 10.
  - On not-taken: 10→11→01→00, saturate at 00.
- Reset:
  - All valid = 0; way w age = w; state = 00; tag/target = 0.
  - rd_vld, rd_hit, rd_taken = 0; rd_target = 0.
- Lookup, 1-cycle latency:
  - rd_req at edge t → rd_vld = 1 after edge t+1, with hit/taken/target computed from array contents before edge t+1's writes.
  - rd_req = 0 → rd_vld = 0; other outputs hold.
  - Miss → rd_hit = 0, rd_taken = 0, rd_target = 0.
  - Multiple ways matching cannot occur; if it does, the lowest way wins.
- Lookup hit: that way becomes MRU (age 0). Every way in the set with age less than the old age increments.
- Update, applied at the edge:
  - Hit: state advances per outcome. If upd_taken, target is overwritten with upd_target. Hit way becomes MRU.
  - Miss and upd_taken: allocate. Victim is the lowest invalid way, else the way with age = NUM_WAYS-1. Write valid = 1, tag, target, state = WT (11); victim becomes MRU.
  - Miss and not-taken: no change.
- Same-set read and update in one cycle:
  - Read returns pre-update data.
  - The update's LRU touch is applied last; the read's touch is dropped.
  - A different-set read and update both apply their touches.
- Ages within a set always remain a permutation of 0..NUM_WAYS-1; the bench asserts this.
- flush:
  - Clears all valid bits and resets ages to w; states are unchanged.
  - Has priority over same-cycle update and read touch.
  - A read issued in the flush cycle returns pre-flush data.
- rst has priority over flush. rst mid-operation discards any in-flight lookup: rd_vld = 0 on the next cycle.
- No stall port: a new request is accepted every cycle.

Decomposition:
- Package btb_pkg holds:
  - state encodings and predicted-taken function;
  - saturating next-state function;
  - entry struct typedef;
  - derived-width localparams.
- Sub-module btb_lru_age, one per set:
  - Inputs: touch_en, touch_way, clear.
  - Outputs: per-way ages, victim way.
  - Keeps the LRU permutation logic isolated and separately testable.

Test Plan:
- After rst, rd_req with rd_pc = 0x0000_1000 → next cycle rd_vld = 1, rd_hit = 0, rd_taken = 0, rd_target = 0.
- Allocation then hit:
  - upd_en with upd_pc = 0x1000, taken, upd_target = 0x2000.
  - Then rd_pc = 0x1000 → rd_hit = 1, rd_taken = 1, rd_target = 0x2000.
  - Entry state is 11.
- Counter walk:
  - Starting from the 0x1000 entry, apply three not-taken updates → states 01, 00, 00; rd_taken = 0; rd_hit stays 1.
  - Then two taken updates → 01, 11; rd_taken = 1.
- LRU eviction, NUM_WAYS = 2, NUM_SETS = 8:
  - Allocate 0x1000 then 0x1020 (same set 0), both taken.
  - Read 0x1000, then allocate 0x1040.
  - 0x1020 is evicted (miss); 0x1000 and 0x1040 hit.
- Same-set collision:
  - Read 0x1000 and update 0x1000 not-taken in the same cycle.
  - rd_taken reflects the old state; the following read reflects the new state.
- Flush and reset:
  - flush with upd_en asserted in the same cycle → all subsequent reads miss, and no allocation occurs.
  - rst asserted the cycle after an rd_req → rd_vld = 0.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer: 2-bit predictor
// encoding and transitions, per-entry metadata and default geometry.
package btb_pkg;

  // Default geometry and the widths derived from it.
  localparam int unsigned DEF_NUM_SETS = 8;
  localparam int unsigned DEF_NUM_WAYS = 2;
  localparam int unsigned DEF_PC_W     = 32;
  localparam int unsigned DEF_IDX_W    = $clog2(DEF_NUM_SETS);
  localparam int unsigned DEF_AGE_W    = $clog2(DEF_NUM_WAYS);
  localparam int unsigned DEF_TAG_W    = DEF_PC_W - 2 - DEF_IDX_W;

  // The MSB alone gives the taken prediction, so the two "taken" states share
  // bit 1 and the walk is a Gray sequence 00-01-11-10.
  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrSt  = 2'b10,
    CtrWt  = 2'b11
  } ctr_e;

  // Width-independent part of an entry; tag and target live in their own arrays
  // because their widths depend on the instance parameters.
  typedef struct packed {
    logic valid;
    ctr_e state;
  } btb_meta_t;

  function automatic logic pred_taken(input ctr_e s);
    return s[1];
  endfunction

  // Saturating counter step: towards St on taken, towards Snt on not-taken.
  function automatic ctr_e ctr_next(input ctr_e s, input logic taken);
    ctr_e n;
    n = s;
    if (taken) begin
      case (s)
        CtrSnt:  n = CtrWnt;
        CtrWnt:  n = CtrWt;
        CtrWt:   n = CtrSt;
        default: n = CtrSt;
      endcase
    end else begin
      case (s)
        CtrSt:   n = CtrWt;
        CtrWt:   n = CtrWnt;
        CtrWnt:  n = CtrSnt;
        default: n = CtrSnt;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/btb_lru_age.sv
// True-LRU age tracker for one set. Ages are a permutation of 0..NUM_WAYS-1,
// 0 being most recently used. Also picks the allocation victim.
module btb_lru_age #(
  parameter  int unsigned NUM_WAYS = 2,
  localparam int unsigned AGE_W    = $clog2(NUM_WAYS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             touch_en,
  input  logic [AGE_W-1:0]                 touch_way,
  input  logic [NUM_WAYS-1:0]              valid,
  output logic [NUM_WAYS-1:0][AGE_W-1:0]   ages,
  output logic [AGE_W-1:0]                 victim
);

  logic [NUM_WAYS-1:0][AGE_W-1:0] age_q, age_d;
  logic [AGE_W-1:0]               old_age;

  // Next ages: clear restores the identity order, a touch makes one way MRU and
  // ages every way that was younger than it.
  always_comb begin
    age_d   = age_q;
    old_age = age_q[touch_way];
    if (clear) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        age_d[w] = AGE_W'(w);
      end
    end else if (touch_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (AGE_W'(w) == touch_way) begin
          age_d[w] = '0;
        end else if (age_q[w] < old_age) begin
          age_d[w] = age_q[w] + 1'b1;
        end
      end
    end
  end

  // Age state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        age_q[w] <= AGE_W'(w);
      end
    end else begin
      age_q <= age_d;
    end
  end

  // Victim: lowest invalid way, otherwise the oldest way. Descending loops so the
  // lowest qualifying way is written last.
  always_comb begin
    victim = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (age_q[w] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = AGE_W'(w);
    end
  end

  assign ages = age_q;

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer. Registered lookup from IF,
// allocate/update from EX, true-LRU replacement per set, whole-array flush.
module btb_assoc #(
  parameter int unsigned NUM_SETS = btb_pkg::DEF_NUM_SETS,
  parameter int unsigned NUM_WAYS = btb_pkg::DEF_NUM_WAYS,
  parameter int unsigned PC_W     = btb_pkg::DEF_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            rd_req,
  input  logic [PC_W-1:0] rd_pc,
  output logic            rd_vld,
  output logic            rd_hit,
  output logic            rd_taken,
  output logic [PC_W-1:0] rd_target,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);
  import btb_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned AGE_W = $clog2(NUM_WAYS);
  localparam int unsigned TAG_W = PC_W - 2 - IDX_W;

  btb_meta_t        meta_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_q  [NUM_SETS][NUM_WAYS];
  logic [PC_W-1:0]  tgt_q  [NUM_SETS][NUM_WAYS];

  logic [NUM_WAYS-1:0][AGE_W-1:0] set_age    [NUM_SETS];
  logic [AGE_W-1:0]               set_victim [NUM_SETS];

  logic [IDX_W-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0] rd_tag, upd_tag;
  logic             rd_match, upd_match;
  logic [AGE_W-1:0] rd_way, upd_way, upd_way_sel;
  logic             upd_write;

  // PC[1:0] never participates in index or tag.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{rd_pc[1:0], upd_pc[1:0]};

  assign rd_idx  = rd_pc[IDX_W+1:2];
  assign rd_tag  = rd_pc[PC_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

  function automatic logic ages_perm(input logic [NUM_WAYS-1:0][AGE_W-1:0] a);
    logic [NUM_WAYS-1:0] seen;
    seen = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      seen[a[w]] = 1'b1;
    end
    return &seen;
  endfunction

  // Lookup tag match; descending scan so the lowest matching way wins.
  always_comb begin
    rd_match = 1'b0;
    rd_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (meta_q[rd_idx][w].valid && tag_q[rd_idx][w] == rd_tag) begin
        rd_match = 1'b1;
        rd_way   = AGE_W'(w);
      end
    end
  end

  // Update tag match, same lowest-way rule.
  always_comb begin
    upd_match = 1'b0;
    upd_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (meta_q[upd_idx][w].valid && tag_q[upd_idx][w] == upd_tag) begin
        upd_match = 1'b1;
        upd_way   = AGE_W'(w);
      end
    end
  end

  // An update writes on a hit or on a taken miss (allocation); flush suppresses it.
  always_comb begin
    upd_write   = upd_en && !flush && (upd_match || upd_taken);
    upd_way_sel = upd_match ? upd_way : set_victim[upd_idx];
  end

  // Registered lookup result; outputs hold when no request is made.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld    <= 1'b0;
      rd_hit    <= 1'b0;
      rd_taken  <= 1'b0;
      rd_target <= '0;
    end else begin
      rd_vld <= rd_req;
      if (rd_req) begin
        rd_hit    <= rd_match;
        rd_taken  <= rd_match && pred_taken(meta_q[rd_idx][rd_way].state);
        rd_target <= rd_match ? tgt_q[rd_idx][rd_way] : '0;
      end
    end
  end

  // Entry storage: reset, flush (valid only), hit update or allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          meta_q[s][w] <= '{valid: 1'b0, state: CtrSnt};
          tag_q[s][w]  <= '0;
          tgt_q[s][w]  <= '0;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          meta_q[s][w].valid <= 1'b0;
        end
      end
    end else if (upd_write) begin
      if (upd_match) begin
        meta_q[upd_idx][upd_way].state <= ctr_next(meta_q[upd_idx][upd_way].state, upd_taken);
        if (upd_taken) tgt_q[upd_idx][upd_way] <= upd_target;
      end else begin
        meta_q[upd_idx][upd_way_sel] <= '{valid: 1'b1, state: CtrWt};
        tag_q[upd_idx][upd_way_sel]  <= upd_tag;
        tgt_q[upd_idx][upd_way_sel]  <= upd_target;
      end
    end
  end

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    logic                touch_en_s;
    logic [AGE_W-1:0]    touch_way_s;
    logic [NUM_WAYS-1:0] valid_s;

    // Per-set touch: an update in this set wins over a lookup hit in it.
    always_comb begin
      touch_en_s  = 1'b0;
      touch_way_s = '0;
      if (upd_write && upd_idx == IDX_W'(s)) begin
        touch_en_s  = 1'b1;
        touch_way_s = upd_way_sel;
      end else if (rd_req && rd_match && rd_idx == IDX_W'(s)) begin
        touch_en_s  = 1'b1;
        touch_way_s = rd_way;
      end
    end

    // Valid vector feeding the victim choice.
    always_comb begin
      valid_s = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        valid_s[w] = meta_q[s][w].valid;
      end
    end

    btb_lru_age #(
      .NUM_WAYS (NUM_WAYS)
    ) u_lru (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .touch_en  (touch_en_s),
      .touch_way (touch_way_s),
      .valid     (valid_s),
      .ages      (set_age[s]),
      .victim    (set_victim[s])
    );

    // Ages must stay a permutation of the way numbers.
    always_ff @(posedge clk) begin
      if (!rst) assert (ages_perm(set_age[s]));
    end
  end

endmodule
